// File: rtl/conv2_pkg.sv
// Shared constants, state encoding and window bit-index helper for the conv2 window buffer.
package conv2_pkg;

  localparam int IMG_W    = 13;
  localparam int IMG_H    = 13;
  localparam int CH       = 8;
  localparam int K        = 3;
  localparam int WIN_BITS = 9 * CH;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Flat window bit position of channel c at kernel row ky, kernel column kx.
  function automatic int win_idx(input int c, input int ky, input int kx);
    return c * K * K + ky * K + kx;
  endfunction

endpackage

// File: rtl/conv2_line_delay.sv
// Enabled shift-register delay line: dout is the sample written DEPTH accepted samples ago.
module conv2_line_delay #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] taps_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      taps_reg[0] <= din;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tap
    always_ff @(posedge clk) begin
      if (en) begin
        taps_reg[gi] <= taps_reg[gi-1];
      end
    end
  end

  assign dout = taps_reg[DEPTH-1];

endmodule

// File: rtl/conv2_window_buf.sv
// Sliding 3x3xCH window assembler between the pool1 pixel stream and the conv2 calculator.
module conv2_window_buf #(
  parameter int IMG_W = conv2_pkg::IMG_W,
  parameter int IMG_H = conv2_pkg::IMG_H,
  parameter int CH    = conv2_pkg::CH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [CH-1:0]   pixel_in,
  output logic [9*CH-1:0] pixel_windows,
  output logic            valid_out_buf,
  output logic            frame_done
);

  import conv2_pkg::K;
  import conv2_pkg::state_t;
  import conv2_pkg::S_FILL;
  import conv2_pkg::S_RUN;
  import conv2_pkg::win_idx;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int WIN_W = 9 * CH;

  state_t state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [K-1:0][K-1:0][CH-1:0] win_reg, win_next;
  logic [CH-1:0]    line1_out, line2_out;
  logic [WIN_W-1:0] win_flat;
  logic             col_last, row_last, emit, done;

  // Rows r-1 and r-2 come out of the cascade as the current pixel goes in.
  conv2_line_delay #(.DEPTH(IMG_W), .WIDTH(CH)) u_line1 (
    .clk  (clk),
    .en   (valid_in),
    .din  (pixel_in),
    .dout (line1_out)
  );

  conv2_line_delay #(.DEPTH(IMG_W), .WIDTH(CH)) u_line2 (
    .clk  (clk),
    .en   (valid_in),
    .din  (line1_out),
    .dout (line2_out)
  );

  assign col_last = (col_reg == COL_W'(IMG_W - 1));
  assign row_last = (row_reg == ROW_W'(IMG_H - 1));

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    win_next   = win_reg;
    emit       = 1'b0;
    done       = 1'b0;
    if (valid_in) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K - 1; kx++) begin
          win_next[ky][kx] = win_reg[ky][kx+1];
        end
      end
      win_next[0][K-1] = line2_out;
      win_next[1][K-1] = line1_out;
      win_next[2][K-1] = pixel_in;

      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end

      case (state_reg)
        S_FILL: begin
          if (col_last && row_reg == ROW_W'(1)) begin
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          // Columns 0 and 1 still carry pixels from the previous row.
          emit = (col_reg >= COL_W'(2));
          done = col_last && row_last;
          if (done) begin
            state_next = S_FILL;
          end
        end
        default: state_next = S_FILL;
      endcase
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    for (genvar gj = 0; gj < K; gj++) begin : g_ky
      for (genvar gk = 0; gk < K; gk++) begin : g_kx
        assign win_flat[win_idx(gi, gj, gk)] = win_next[gj][gk][gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FILL;
      col_reg       <= '0;
      row_reg       <= '0;
      win_reg       <= '0;
      pixel_windows <= '0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      win_reg       <= win_next;
      valid_out_buf <= emit;
      frame_done    <= done;
      if (emit) begin
        pixel_windows <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// Randomized bench for conv2_window_buf against a frame-array reference of 3x3 neighbourhoods.
module tb_conv2_window_buf;

  localparam int W  = 13;
  localparam int H  = 13;
  localparam int C  = 8;
  localparam int WB = 9 * C;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [C-1:0]  pixel_in;
  logic [WB-1:0] pixel_windows;
  logic          valid_out_buf;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [C-1:0]  img [H][W];
  int            m_idx;
  logic [WB-1:0] exp_win;

  always #5 clk = ~clk;

  conv2_window_buf #(.IMG_W(W), .IMG_H(H), .CH(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .pixel_in      (pixel_in),
    .pixel_windows (pixel_windows),
    .valid_out_buf (valid_out_buf),
    .frame_done    (frame_done)
  );

  function automatic logic [WB-1:0] ref_window(input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int ch = 0; ch < C; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          w[ch*9 + ky*3 + kx] = img[r-2+ky][c-2+kx][ch];
    return w;
  endfunction

  task automatic model_reset();
    m_idx   = 0;
    exp_win = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; pixel_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one cycle; returns expected valid/frame_done, leaves expected window in exp_win.
  task automatic step(input logic v, input logic [C-1:0] pix, output logic ev, output logic efd);
    int r, c;
    valid_in = v; pixel_in = pix;
    ev = 1'b0; efd = 1'b0;
    if (v) begin
      r = m_idx / W; c = m_idx % W;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        exp_win = ref_window(r, c);
      end
      efd = (m_idx == NPIX - 1);
      m_idx = (m_idx + 1) % NPIX;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    logic ev, efd;
    int pulses;
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), C'($urandom), ev, efd);
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; valid_in = 1'($urandom_range(0, 1)); pixel_in = C'($urandom);
      @(posedge clk); #1;
      n_cmp += 3;
      if (valid_out_buf !== 1'b0) begin n_bad++; $display("FAIL reset_valid cyc=%0d got %b want 0", i, valid_out_buf); end
      if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done cyc=%0d got %b want 0", i, frame_done); end
      if (pixel_windows !== '0) begin n_bad++; $display("FAIL reset_win cyc=%0d got %h want 0", i, pixel_windows); end
    end
    rst = 1'b0; valid_in = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 29; i++) begin
      step(1'b1, C'($urandom), ev, efd);
      n_cmp += 2;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL reset_fill_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL reset_fill_win pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      if (valid_out_buf) pulses++;
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL reset_first_pulse got %0d pulses want 1 after 29 pixels", pulses); end
  endtask

  task automatic test_all_ones();
    logic ev, efd;
    int pulses, first, fd_at;
    do_reset();
    pulses = 0; first = -1; fd_at = -1;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, '1, ev, efd);
      n_cmp += 2;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL ones_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (frame_done !== efd) begin n_bad++; $display("FAIL ones_done pix=%0d got %b want %b", i, frame_done, efd); end
      if (valid_out_buf) begin
        pulses++;
        if (first < 0) first = i;
        n_cmp++;
        if (pixel_windows !== {WB{1'b1}}) begin n_bad++; $display("FAIL ones_win pix=%0d got %h want all ones", i, pixel_windows); end
      end
      if (frame_done) fd_at = pulses;
    end
    n_cmp += 3;
    if (pulses !== NWIN) begin n_bad++; $display("FAIL ones_count got %0d want %0d", pulses, NWIN); end
    if (first !== 2*W + 2) begin n_bad++; $display("FAIL ones_first got pix %0d want %0d", first, 2*W + 2); end
    if (fd_at !== NWIN) begin n_bad++; $display("FAIL ones_done_pos got pulse %0d want %0d", fd_at, NWIN); end
  endtask

  task automatic test_single_bit(input int pos, input logic [C-1:0] val, input logic [WB-1:0] first_want, input logic rest_zero);
    logic ev, efd;
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, (i == pos) ? val : '0, ev, efd);
      n_cmp += 2;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL bit_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL bit_win pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      if (valid_out_buf) begin
        pulses++;
        if (pulses == 1) begin
          n_cmp++;
          if (pixel_windows !== first_want) begin n_bad++; $display("FAIL bit_first got %h want %h", pixel_windows, first_want); end
        end else if (rest_zero) begin
          n_cmp++;
          if (pixel_windows !== '0) begin n_bad++; $display("FAIL bit_later pix=%0d got %h want 0", i, pixel_windows); end
        end
      end
    end
  endtask

  task automatic test_raster_gaps();
    logic ev, efd;
    int pulses, fds;
    do_reset();
    pulses = 0; fds = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, C'(i % 256), ev, efd);
      n_cmp += 3;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL gap_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (frame_done !== efd) begin n_bad++; $display("FAIL gap_done pix=%0d got %b want %b", i, frame_done, efd); end
      if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL gap_win pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      if (valid_out_buf) pulses++;
      if (frame_done) fds++;
      for (int g = $urandom_range(0, 5); g > 0; g--) begin
        step(1'b0, C'($urandom), ev, efd);
        n_cmp += 2;
        if (valid_out_buf !== 1'b0) begin n_bad++; $display("FAIL gap_idle_valid pix=%0d got %b want 0", i, valid_out_buf); end
        if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL gap_hold pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      end
    end
    n_cmp += 2;
    if (pulses !== NWIN) begin n_bad++; $display("FAIL gap_count got %0d want %0d", pulses, NWIN); end
    if (fds !== 1) begin n_bad++; $display("FAIL gap_done_count got %0d want 1", fds); end
  endtask

  task automatic test_mid_frame_reset();
    logic ev, efd;
    int pulses;
    do_reset();
    for (int i = 0; i <= 50; i++) step(1'b1, C'($urandom_range(1, 255)), ev, efd);
    do_reset();
    pulses = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, C'($urandom), ev, efd);
      n_cmp += 3;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL mid_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (frame_done !== efd) begin n_bad++; $display("FAIL mid_done pix=%0d got %b want %b", i, frame_done, efd); end
      if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL mid_win pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      if (valid_out_buf) pulses++;
    end
    n_cmp++;
    if (pulses !== NWIN) begin n_bad++; $display("FAIL mid_count got %0d want %0d", pulses, NWIN); end
  endtask

  task automatic test_back_to_back();
    logic ev, efd;
    int pulses, fds;
    do_reset();
    pulses = 0; fds = 0;
    for (int i = 0; i < 2*NPIX; i++) begin
      step(1'b1, (i < NPIX) ? C'($urandom) : '0, ev, efd);
      n_cmp += 3;
      if (valid_out_buf !== ev) begin n_bad++; $display("FAIL b2b_valid pix=%0d got %b want %b", i, valid_out_buf, ev); end
      if (frame_done !== efd) begin n_bad++; $display("FAIL b2b_done pix=%0d got %b want %b", i, frame_done, efd); end
      if (pixel_windows !== exp_win) begin n_bad++; $display("FAIL b2b_win pix=%0d got %h want %h", i, pixel_windows, exp_win); end
      if (valid_out_buf) begin
        pulses++;
        if (i >= NPIX) begin
          n_cmp++;
          if (pixel_windows !== '0) begin n_bad++; $display("FAIL b2b_zero pix=%0d got %h want 0", i, pixel_windows); end
        end
      end
      if (frame_done) fds++;
    end
    n_cmp += 2;
    if (pulses !== 2*NWIN) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", pulses, 2*NWIN); end
    if (fds !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", fds); end
  endtask

  initial begin
    logic [WB-1:0] bit0, bit71;
    bit0  = '0; bit0[0]   = 1'b1;
    bit71 = '0; bit71[71] = 1'b1;
    rst = 1'b1; valid_in = 1'b0; pixel_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_all_ones();
    test_single_bit(0, 8'h01, bit0, 1'b1);
    test_single_bit(2*W + 2, 8'h80, bit71, 1'b0);
    test_raster_gaps();
    test_mid_frame_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
